column_select_ctrl: RTL and testbench

COLUMN_SELECT_CTRL -- requirements
Module: column_select_ctrl

---
 rtl/column_select_ctrl.sv | 147 ++++++++++++++
 tb/tb_column_select_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/column_select_ctrl.sv
// -----------------------------------------------------------------------------
// column_select_ctrl
//
// Column-select sequencer for a memory array. It accepts a burst request
// (first column plus length-minus-one). For each column in the burst it
// optionally runs one bitline precharge cycle, then drives a one-hot column
// select for one cycle. The column address increments and wraps modulo
// NUM_COLS.
//
// Build option:
//   COLUMN_SELECT_PRECHARGE_EN  when defined, each select is preceded by one
//                               PRECHARGE cycle. When undefined, selects run
//                               back to back and precharge is tied low.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  block idle and able to accept a request
//   req_addr    in   first column of the burst       [ADDR_WIDTH]
//   req_len     in   burst length minus one          [LEN_WIDTH]
//   col_select  out  registered one-hot column select [NUM_COLS]
//   col_valid   out  col_select carries an asserted column
//   col_addr    out  binary index of the asserted column (0 when idle)
//   precharge   out  bitline precharge phase active
//   busy        out  burst in progress
// -----------------------------------------------------------------------------
module column_select_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int LEN_WIDTH  = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ADDR_WIDTH-1:0]      req_addr,
   input  logic [LEN_WIDTH-1:0]       req_len,
   output logic [(2**ADDR_WIDTH)-1:0] col_select,
   output logic                       col_valid,
   output logic [ADDR_WIDTH-1:0]      col_addr,
   output logic                       precharge,
   output logic                       busy
);

   localparam int NUM_COLS = 2**ADDR_WIDTH;

`ifdef COLUMN_SELECT_PRECHARGE_EN
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRECHARGE = 2'd1,
      SELECT    = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SELECT    = 2'd2
   } state_t;
`endif

   state_t                state_p0, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_p0,  addr_nxt;
   logic [LEN_WIDTH-1:0]  cnt_p0,   cnt_nxt;
   logic                  handshake;

   function automatic logic [NUM_COLS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
      logic [NUM_COLS-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

   assign req_ready = (state_p0 == IDLE) && !rst;
   assign handshake = req_valid && req_ready;

   // Next-state: the address/count are latched only on handshake, so req_*
   // activity during a burst cannot disturb it.
   always_comb begin
      state_nxt = state_p0;
      addr_nxt  = addr_p0;
      cnt_nxt   = cnt_p0;
      case (state_p0)
         IDLE: begin
            if (handshake) begin
               addr_nxt  = req_addr;
               cnt_nxt   = req_len;
`ifdef COLUMN_SELECT_PRECHARGE_EN
               state_nxt = PRECHARGE;
`else
               state_nxt = SELECT;
`endif
            end
         end
`ifdef COLUMN_SELECT_PRECHARGE_EN
         PRECHARGE: state_nxt = SELECT;
`endif
         SELECT: begin
            if (cnt_p0 != '0) begin
               addr_nxt  = addr_p0 + ADDR_WIDTH'(1);
               cnt_nxt   = cnt_p0 - LEN_WIDTH'(1);
`ifdef COLUMN_SELECT_PRECHARGE_EN
               state_nxt = PRECHARGE;
`else
               state_nxt = SELECT;
`endif
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers. Outputs are decoded from the next state so
   // col_select comes straight from flops and lines up with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0   <= IDLE;
         addr_p0    <= '0;
         cnt_p0     <= '0;
         col_select <= '0;
         col_valid  <= 1'b0;
         col_addr   <= '0;
         busy       <= 1'b0;
      end else begin
         state_p0   <= state_nxt;
         addr_p0    <= addr_nxt;
         cnt_p0     <= cnt_nxt;
         col_select <= (state_nxt == SELECT) ? onehot(addr_nxt) : '0;
         col_valid  <= (state_nxt == SELECT);
         col_addr   <= (state_nxt == SELECT) ? addr_nxt : '0;
         busy       <= (state_nxt != IDLE);
      end
   end

`ifdef COLUMN_SELECT_PRECHARGE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         precharge <= 1'b0;
      end else begin
         precharge <= (state_nxt == PRECHARGE);
      end
   end
`else
   assign precharge = 1'b0;
`endif

endmodule

// File: tb/tb_column_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_column_select_ctrl
//
// Scoreboard bench for column_select_ctrl (ADDR_WIDTH=4, LEN_WIDTH=3). An
// observer on the rising edge turns each accepted request into timed expected
// precharge/select events; a monitor on the falling edge pops and compares
// them against the DUT outputs every cycle. Select sequences are also checked
// against hand-written tables. Works with or without
// COLUMN_SELECT_PRECHARGE_EN defined.
// -----------------------------------------------------------------------------
module tb_column_select_ctrl;

   localparam int AW = 4;
   localparam int LW = 3;
   localparam int NC = 16;
`ifdef COLUMN_SELECT_PRECHARGE_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   typedef struct {
      int          ed;
      bit          pre;
      logic [AW-1:0] addr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_len = '0;
   logic          req_ready;
   logic [NC-1:0] col_select;
   logic          col_valid;
   logic [AW-1:0] col_addr;
   logic          precharge;
   logic          busy;

   column_select_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .col_select (col_select),
      .col_valid  (col_valid),
      .col_addr   (col_addr),
      .precharge  (precharge),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int            edge_cnt = 0;
   exp_t          q[$];
   int            win_first = 1;
   int            win_last = 0;
   int            hs_count = 0;
   bit            chk_en = 1'b0;
   int            total = 0;
   int            bad = 0;
   logic [NC-1:0] obs_log[$];
   logic [NC-1:0] exp_log[$];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic bit busy_at(int e);
      return (e >= win_first) && (e <= win_last);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      total = total + 1;
      if (act !== req) begin
         bad = bad + 1;
         $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, req);
      end
   endtask

   // Observer: models acceptance and schedules expected events.
   always @(posedge clk) begin
      int   h;
      exp_t e;
      h = edge_cnt + 1;
      if (rst) begin
         q.delete();
         if (win_last >= h) win_last = h - 1;
      end else if (req_valid && !busy_at(edge_cnt)) begin
         for (int k = 0; k <= int'(req_len); k++) begin
            e.addr = req_addr + AW'(k);
            if (PRE) begin
               e.ed = h + 2*k;     e.pre = 1'b1; q.push_back(e);
               e.ed = h + 2*k + 1; e.pre = 1'b0; q.push_back(e);
            end else begin
               e.ed = h + k;       e.pre = 1'b0; q.push_back(e);
            end
         end
         win_first = h;
         win_last  = h + (PRE ? 2 : 1) * (int'(req_len) + 1) - 1;
         hs_count  = hs_count + 1;
      end
   end

   // Monitor: compares every cycle against the scheduled expectation.
   always @(negedge clk) begin
      exp_t          e;
      bit            ev;
      bit            ep;
      logic [AW-1:0] ea;
      logic [NC-1:0] es;
      bit            eb;
      if (chk_en) begin
         ev = 1'b0; ep = 1'b0; ea = '0;
         if (q.size() > 0 && q[0].ed == edge_cnt) begin
            e = q.pop_front();
            if (e.pre) ep = 1'b1;
            else begin
               ev = 1'b1;
               ea = e.addr;
            end
         end
         es = '0;
         if (ev) es[ea] = 1'b1;
         eb = busy_at(edge_cnt);
         chk("col_valid",  32'(col_valid),  32'(ev));
         chk("col_select", 32'(col_select), 32'(es));
         chk("col_addr",   32'(col_addr),   32'(ea));
         chk("precharge",  32'(precharge),  32'(ep));
         chk("busy",       32'(busy),       32'(eb));
         chk("req_ready",  32'(req_ready),  32'(!rst && !eb));
         if (col_valid) obs_log.push_back(col_select);
      end
   end

   task automatic wait_hs();
      int start;
      bit got;
      start = hs_count;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (hs_count != start) begin
            got = 1'b1;
            break;
         end
      end
      chk("handshake_wait", 32'(got), 32'd1);
   endtask

   task automatic do_req(logic [AW-1:0] a, logic [LW-1:0] l, bit keep);
      @(posedge clk); #1;
      req_addr  = a;
      req_len   = l;
      req_valid = 1'b1;
      wait_hs();
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (q.size() == 0 && !busy_at(edge_cnt)) begin
            done = 1'b1;
            break;
         end
      end
      chk("idle_wait", 32'(done), 32'd1);
   endtask

   task automatic check_log(string name);
      chk({name, "_count"}, 32'(obs_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size(); i++) begin
         if (i < obs_log.size()) chk(name, 32'(obs_log[i]), 32'(exp_log[i]));
      end
      obs_log.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_col_select", 32'(col_select), 32'd0);
      chk("rst_col_valid",  32'(col_valid),  32'd0);
      chk("rst_col_addr",   32'(col_addr),   32'd0);
      chk("rst_precharge",  32'(precharge),  32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      obs_log.delete();

      // single column
      do_req(4'd5, 3'd0, 1'b0);
      wait_idle();
      exp_log = '{16'h0020};
      check_log("single_5");

      // wrap across NUM_COLS-1
      do_req(4'd14, 3'd3, 1'b0);
      wait_idle();
      exp_log = '{16'h4000, 16'h8000, 16'h0001, 16'h0002};
      check_log("wrap_14");

      // from column 0
      do_req(4'd0, 3'd2, 1'b0);
      wait_idle();
      exp_log = '{16'h0001, 16'h0002, 16'h0004};
      check_log("burst_0");

      // req_valid held with changed inputs during a burst
      do_req(4'd9, 3'd2, 1'b1);
      req_addr = 4'd3;
      req_len  = 3'd1;
      wait_hs();
      req_valid = 1'b0;
      wait_idle();
      exp_log = '{16'h0200, 16'h0400, 16'h0800, 16'h0008, 16'h0010};
      check_log("hold_valid");

      // reset during the second select of a len=3 burst
      do_req(4'd2, 3'd3, 1'b0);
      repeat (PRE ? 3 : 1) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready),  32'd1);
      chk("post_rst_sel",   32'(col_select), 32'd0);
      wait_idle();
      repeat (4) @(posedge clk);
      exp_log = '{16'h0004, 16'h0008};
      check_log("rst_abort");

      // maximum length with wrap
      do_req(4'd12, 3'd7, 1'b0);
      wait_idle();
      exp_log = '{16'h1000, 16'h2000, 16'h4000, 16'h8000,
                  16'h0001, 16'h0002, 16'h0004, 16'h0008};
      check_log("max_len");

      repeat (4) @(posedge clk);
      #1;
      chk("drain", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
